sonic_tx_arbiter: RTL
=====================

# sonic_tx_arbiter

Shares the single PCIe core TX descriptor/data interface among NUM_REQ transmit requesters: DMA read engine, DMA write engine and the RC slave completion path. Round-robin arbitration at packet granularity, one-hot `tx_sel` back to each requester, combinational steering of the granted requester's TX signals to the core and of `tx_ack`/`tx_ws` back to it. Sits between the per-channel requesters and the hard-IP TX port in each SoNIC port.

## Interface
- NUM_REQ, 3, number of requesters (index 0 = DMA read, 1 = DMA write, 2 = RC slave)
- TX_DW, 128, TX data width
- GRANT_TIMEOUT, 15, cycles to wait for granted requester to raise busy before reclaiming grant
- clk_in  in  1  clock; one clock domain
- rstn  in  1  reset, asynchronous, active-low
- req_tx_ready  in  NUM_REQ  requester has a packet pending
- req_tx_busy  in  NUM_REQ  requester is transmitting a packet
- req_tx_req  in  NUM_REQ  per-requester tx_req
- req_tx_desc  in  NUM_REQ*128  packed descriptors, requester i at [i*128 +: 128]
- req_tx_data  in  NUM_REQ*TX_DW  packed data
- req_tx_dfr, req_tx_dv  in  NUM_REQ each  per-requester dfr/dv
- req_tx_sel  out  NUM_REQ  one-hot grant, registered
- req_tx_ack, req_tx_ws  out  NUM_REQ each  core ack/ws routed to granted requester only
- tx_req, tx_dfr, tx_dv  out  1  to core
- tx_desc  out  128, tx_data  out  TX_DW  to core
- tx_ack, tx_ws  in  1  from core
- arb_timeout  out  1  one-cycle pulse when a grant is reclaimed by timeout

## Operation
- FSM states: IDLE, GRANT, BUSY, RELEASE.
- IDLE: if any `req_tx_ready` set, pick first set bit at or after `rr_ptr` (wrapping modulo NUM_REQ); register one-hot into `req_tx_sel`; load `winner`; clear timeout counter; -> GRANT. No requests: stay, `req_tx_sel`=0.
- GRANT: if `req_tx_busy[winner]` -> BUSY. Else increment counter; at GRANT_TIMEOUT -> RELEASE with `arb_timeout` pulse.
- BUSY: hold grant while `req_tx_busy[winner]`; on fall -> RELEASE.
- RELEASE: `req_tx_sel` cleared; `rr_ptr` = winner+1 (wraps NUM_REQ-1 -> 0); -> IDLE. Timeout release advances pointer identically (a stuck requester cannot starve others).
- Steering: core outputs = fields of requester indexed by `winner`, AND-gated by `req_tx_sel != 0`; with no grant `tx_req`/`tx_dfr`/`tx_dv` = 0, `tx_desc`/`tx_data` = 0.
- `req_tx_ack[i]` = `tx_ack & req_tx_sel[i]`; same for `req_tx_ws`. Non-granted requesters see ws=0, ack=0.
- Ready/busy from non-granted requesters ignored while not IDLE.

## Timing
- Reset (async assert): state IDLE, `rr_ptr`=0, `winner`=0, counter 0, `req_tx_sel`=0, `arb_timeout`=0; hence all core-side outputs and ack/ws 0. Deassert sync to clk_in.
- Arbitration latency: ready sampled cycle N -> `req_tx_sel` high cycle N+1.
- Grant drop: busy low sampled cycle M -> RELEASE in M+1 (`req_tx_sel` 0 at M+2 edge); earliest next grant at M+3 visible. Mandatory one-cycle idle gap between packets.
- Timeout: `arb_timeout` high exactly the cycle FSM is in RELEASE via timeout path.
- Ready and busy both high in GRANT entry cycle: go straight to BUSY.
- Requester dropping ready in GRANT without busy: timeout path.
- Steering paths purely combinational from registered `winner`/`req_tx_sel`; no data pipelining.

## Structure
- Shared constants package: `tx_arb_state_t` enum, TX descriptor width 128, requester index constants (REQ_DMA_RD=0, REQ_DMA_WR=1, REQ_RC_SLAVE=2) alongside existing `sonic_constants.sv` defines.
- One sub-module: `sonic_rr_picker` (combinational; request vector + pointer -> one-hot + index + valid).

## Test plan
- Single requester 2 ready cycle 10 -> `req_tx_sel`=3'b100 cycle 11; its desc/data appear on core; busy falls cycle 20 -> sel 0 by cycle 22.
- All three ready continuously, each busy 4 cycles -> grant order 0,1,2,0,1,2; one idle cycle between grants.
- After grant to 2, pointer wraps: requesters 0 and 2 ready -> 0 granted next.
- Requester 1 granted, never raises busy -> after 15 GRANT cycles `arb_timeout` one pulse, next grant goes to 2.
- Core asserts tx_ws/tx_ack during grant to 0 -> only `req_tx_ws[0]`/`req_tx_ack[0]` toggle; others stay 0.
- rstn low mid-BUSY -> immediately sel 0, tx_req/dv/dfr 0; after release, first grant from pointer 0.

Source files
------------

// File: rtl/sonic_tx_arbiter_pkg.sv
// sonic_tx_arbiter_pkg: shared constants and types for the PCIe TX arbiter
package sonic_tx_arbiter_pkg;
  localparam int TX_DESC_W = 128;
  localparam int REQ_DMA_RD = 0;
  localparam int REQ_DMA_WR = 1;
  localparam int REQ_RC_SLAVE = 2;
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} tx_arb_state_t;
endpackage

// File: rtl/sonic_rr_picker.sv
// sonic_rr_picker: combinational round-robin pick of the first set request at or after ptr
//   req   - request vector
//   ptr   - round-robin start index
//   grant - one-hot of the chosen request
//   idx   - index of the chosen request
//   valid - some request is set
module sonic_rr_picker #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++)
      if (!valid && req[i] && IW'(i) >= ptr) begin
        valid = 1'b1;
        idx = IW'(i);
      end
    for (int i = 0; i < N; i++)
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx = IW'(i);
      end
    grant = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sonic_tx_arbiter.sv
// sonic_tx_arbiter: packet-granular round-robin share of the PCIe core TX port
//   clk_in, rstn                  - clock, async active-low reset
//   req_tx_ready/busy             - per-requester packet pending / transmitting
//   req_tx_req/desc/data/dfr/dv   - per-requester TX signals, packed by index
//   req_tx_sel                    - registered one-hot grant
//   req_tx_ack/ws                 - core ack/ws routed to the granted requester
//   tx_req/desc/data/dfr/dv       - steered TX signals to the core
//   tx_ack/ws                     - from the core
//   arb_timeout                   - pulse when a stalled grant is reclaimed
module sonic_tx_arbiter
  import sonic_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TX_DW = 128,
  parameter int GRANT_TIMEOUT = 15
) (
  input  logic                           clk_in,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_tx_ready,
  input  logic [NUM_REQ-1:0]             req_tx_busy,
  input  logic [NUM_REQ-1:0]             req_tx_req,
  input  logic [NUM_REQ*TX_DESC_W-1:0]   req_tx_desc,
  input  logic [NUM_REQ*TX_DW-1:0]       req_tx_data,
  input  logic [NUM_REQ-1:0]             req_tx_dfr,
  input  logic [NUM_REQ-1:0]             req_tx_dv,
  output logic [NUM_REQ-1:0]             req_tx_sel,
  output logic [NUM_REQ-1:0]             req_tx_ack,
  output logic [NUM_REQ-1:0]             req_tx_ws,
  output logic                           tx_req,
  output logic                           tx_dfr,
  output logic                           tx_dv,
  output logic [TX_DESC_W-1:0]           tx_desc,
  output logic [TX_DW-1:0]               tx_data,
  input  logic                           tx_ack,
  input  logic                           tx_ws,
  output logic                           arb_timeout
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);
  tx_arb_state_t state, state_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx, winner, winner_nx, pick_idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_REQ-1:0] sel_nx, pick_oh;
  logic pick_valid, timeout_nx, granted, win_busy;
  sonic_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req(req_tx_ready),
    .ptr(rr_ptr),
    .grant(pick_oh),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign win_busy = req_tx_busy[winner];
  always_ff @(posedge clk_in or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      rr_ptr <= '0;
      winner <= '0;
      cnt <= '0;
      req_tx_sel <= '0;
      arb_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_ptr_nx;
      winner <= winner_nx;
      cnt <= cnt_nx;
      req_tx_sel <= sel_nx;
      arb_timeout <= timeout_nx;
    end
  // Grant stays visible through RELEASE; it drops on the way back to IDLE,
  // which forces one idle cycle between packets.
  always_comb begin
    state_nx = state;
    rr_ptr_nx = rr_ptr;
    winner_nx = winner;
    cnt_nx = cnt;
    sel_nx = req_tx_sel;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        sel_nx = pick_oh;
        if (pick_valid) begin
          winner_nx = pick_idx;
          cnt_nx = '0;
          state_nx = GRANT;
        end
      end
      GRANT:
        if (win_busy) state_nx = BUSY;
        else begin
          cnt_nx = cnt + 1'b1;
          if (cnt_nx == CW'(GRANT_TIMEOUT)) begin
            state_nx = RELEASE;
            timeout_nx = 1'b1;
          end
        end
      BUSY: state_nx = win_busy ? BUSY : RELEASE;
      default: begin
        sel_nx = '0;
        rr_ptr_nx = winner == IW'(NUM_REQ - 1) ? '0 : winner + 1'b1;
        state_nx = IDLE;
      end
    endcase
  end
  assign granted = |req_tx_sel;
  assign tx_req = granted & req_tx_req[winner];
  assign tx_dfr = granted & req_tx_dfr[winner];
  assign tx_dv = granted & req_tx_dv[winner];
  assign tx_desc = granted ? req_tx_desc[winner*TX_DESC_W +: TX_DESC_W] : '0;
  assign tx_data = granted ? req_tx_data[winner*TX_DW +: TX_DW] : '0;
  assign req_tx_ack = {NUM_REQ{tx_ack}} & req_tx_sel;
  assign req_tx_ws = {NUM_REQ{tx_ws}} & req_tx_sel;
endmodule
